// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: datapath/control widths, control-bundle field
// positions and small helpers used by the ID/EX register and the forwarding unit.
package id_ex_stage_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int CTRL_W_DEF   = 16;
    localparam int REG_IDX_W    = 5;
    localparam int BUBBLE_CNT_W = 16;

    // Bit positions inside the decoded control bundle
    localparam int CTRL_ALU_OP_LSB     = 0;
    localparam int CTRL_ALU_OP_W       = 4;
    localparam int CTRL_ALU_SRC_BIT    = 4;
    localparam int CTRL_REG_WRITE_BIT  = 5;
    localparam int CTRL_MEM_WRITE_BIT  = 6;
    localparam int CTRL_MEM_TO_REG_BIT = 7;
    localparam int CTRL_BRANCH_BIT     = 8;
    localparam int CTRL_JUMP_BIT       = 9;

    typedef logic [REG_IDX_W-1:0]    reg_idx_t;
    typedef logic [BUBBLE_CNT_W-1:0] bubble_cnt_t;

    function automatic bubble_cnt_t sat_inc(input bubble_cnt_t v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detector: an ID instruction reading the
// destination of a load still sitting in EX must wait one cycle.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic     i_id_valid,
    input  reg_idx_t i_id_rs,
    input  reg_idx_t i_id_rt,
    input  logic     i_id_uses_rs,
    input  logic     i_id_uses_rt,
    input  logic     i_ex_valid,
    input  logic     i_ex_mem_read,
    input  reg_idx_t i_ex_rd,
    output logic     o_hazard
);

    logic w_rs_match;
    logic w_rt_match;
    logic w_rd_nonzero;

    assign w_rs_match   = i_id_uses_rs && (i_ex_rd == i_id_rs);
    assign w_rt_match   = i_id_uses_rt && (i_ex_rd == i_id_rt);
    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign w_rd_nonzero = (i_ex_rd != '0);

    assign o_hazard = i_id_valid && i_ex_valid && i_ex_mem_read && w_rd_nonzero
                      && (w_rs_match || w_rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, load-use bubble
// insertion, branch flush and a saturating inserted-bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              load_use_stall,
    output logic [15:0]       bubble_cnt
);

    logic              r_ex_valid;
    logic [4:0]        r_ex_rs;
    logic [4:0]        r_ex_rt;
    logic [4:0]        r_ex_rd;
    logic [DATA_W-1:0] r_ex_rd1;
    logic [DATA_W-1:0] r_ex_rd2;
    logic [DATA_W-1:0] r_ex_imm;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic              r_ex_mem_read;
    bubble_cnt_t       r_bubble_cnt;

    logic w_hazard;
    logic w_advance;
    logic w_bubble;
    logic w_load;

    load_use_detect u_load_use_detect (
        .i_id_valid    (id_valid),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_uses_rs  (id_uses_rs),
        .i_id_uses_rt  (id_uses_rt),
        .i_ex_valid    (r_ex_valid),
        .i_ex_mem_read (r_ex_mem_read),
        .i_ex_rd       (r_ex_rd),
        .o_hazard      (w_hazard)
    );

    assign w_advance      = ex_ready || !r_ex_valid;
    assign w_bubble       = w_advance && w_hazard && !flush;
    assign w_load         = w_advance && !w_hazard && !flush;
    assign load_use_stall = w_hazard && !flush;
    // A flush drops the ID instruction, so ID is always free to move on
    assign id_ready       = flush || (w_advance && !w_hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_rs       <= '0;
            r_ex_rt       <= '0;
            r_ex_rd       <= '0;
            r_ex_rd1      <= '0;
            r_ex_rd2      <= '0;
            r_ex_imm      <= '0;
            r_ex_ctrl     <= '0;
            r_ex_mem_read <= 1'b0;
        end else if (flush || w_bubble) begin
            r_ex_valid    <= 1'b0;
            r_ex_ctrl     <= '0;
            r_ex_mem_read <= 1'b0;
        end else if (w_load) begin
            r_ex_valid    <= id_valid;
            r_ex_rs       <= id_rs;
            r_ex_rt       <= id_rt;
            r_ex_rd       <= id_rd;
            r_ex_rd1      <= id_rd1;
            r_ex_rd2      <= id_rd2;
            r_ex_imm      <= id_imm;
            r_ex_ctrl     <= id_valid ? id_ctrl : '0;
            r_ex_mem_read <= id_valid && id_mem_read;
        end
    end

    // Only load-use bubbles are counted; flush squashes are not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble) begin
            r_bubble_cnt <= sat_inc(r_bubble_cnt);
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_rs       = r_ex_rs;
    assign ex_rt       = r_ex_rt;
    assign ex_rd       = r_ex_rd;
    assign ex_rd1      = r_ex_rd1;
    assign ex_rd2      = r_ex_rd2;
    assign ex_imm      = r_ex_imm;
    assign ex_ctrl     = r_ex_ctrl;
    assign ex_mem_read = r_ex_mem_read;
    assign bubble_cnt  = r_bubble_cnt;

endmodule
